multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have parameter OP_W, default 6, meaning opcode width.
REQ-002 The block SHALL have parameter ALUOP_W, default 3, meaning ALUOp width.
REQ-003 The block SHALL have parameter MEM_LAT, default 1, legal 1..15, meaning cycles spent in MEM per load/store.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port Opcode, input, OP_W bits: instruction opcode from the instruction register.
REQ-007 The block SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-008 The block SHALL have ports PCWre and IRWre, output, 1 bit each: PC write and IR write enables.
REQ-009 The block SHALL have ports RegWre and DataMemRW, output, 1 bit each: register write and data-memory write (1 = write).
REQ-010 The block SHALL have ports ALUSrcB, ALUM2Reg, RegOut and ExtSel, output, 1 bit each: B = immediate; write-back from memory; destination = rd; sign-extend.
REQ-011 The block SHALL have port ALUOp, output, ALUOP_W bits: ALU function.
REQ-012 The block SHALL have port PCSrc, output, 2 bits: 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-013 The block SHALL have port State, output, 3 bits: current state, for debug.

Function
REQ-014 The block SHALL decode opcodes ADD 000000, SUB 000001, ADDI 000010, OR 010000, AND 010001, ORI 010010, SLT 011000, SW 100110, LW 100111, BEQ 110000, BNE 110001, J 111000 and HALT 111111.
REQ-015 The block SHALL implement states IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111, plus a HALT state.
- HALT is encoded internally; State reads 111 while WB_AL is inactive is not allowed, so HALT SHALL drive State = 001 held with all enables 0.
REQ-016 The block SHALL sequence IF->ID unconditionally.
REQ-017 The block SHALL leave ID according to the opcode: ALU/imm -> EXE_AL; LW/SW -> EXE_LS; BEQ/BNE -> EXE_BR; J -> IF; HALT -> HALT; undefined opcode -> IF (NOP).
REQ-018 The block SHALL sequence EXE_AL->WB_AL->IF, EXE_BR->IF, EXE_LS->MEM, and MEM->WB_LD (LW) or MEM->IF (SW) after MEM_LAT cycles; WB_LD->IF.
REQ-019 The block SHALL latch Opcode in ID and decode all later states from the latched value, so that a changing Opcode input after ID has no effect.
REQ-020 The block SHALL drive IRWre=1 and PCWre=1 with PCSrc=00 in IF only.
REQ-021 The block SHALL drive PCWre=1 with PCSrc=10 in ID for J.
REQ-022 The block SHALL drive PCSrc=01 in EXE_BR, with PCWre=Zero for BEQ and PCWre=~Zero for BNE.
REQ-023 The block SHALL drive ALUOp as ADD/ADDI/LW/SW 000, SUB/BEQ/BNE 001, OR/ORI 011, AND 100, SLT 101; ALUOp SHALL be held from EXE through WB.
REQ-024 The block SHALL drive ALUSrcB=1 for ADDI, ORI, LW and SW.
REQ-025 The block SHALL drive ExtSel=0 for ORI and ExtSel=1 otherwise.
REQ-026 The block SHALL drive RegOut=1 for R-type instructions and ALUM2Reg=1 for LW.
REQ-027 The block SHALL drive RegWre=1 only in WB_AL and WB_LD, for exactly 1 cycle.
REQ-028 The block SHALL drive DataMemRW=1 only in MEM for SW, for exactly MEM_LAT consecutive cycles.
REQ-029 The block SHALL hold HALT, with all enables 0, until Reset.
REQ-030 The block SHALL compute all outputs as Moore functions of the state and the latched opcode, except PCWre in EXE_BR, which SHALL depend on Zero combinationally.

Reset
REQ-031 The block SHALL, on a rising CLK edge with Reset=1, set state to IF, clear the MEM counter and clear the latched opcode to 000000.
REQ-032 The block SHALL force PCWre, IRWre, RegWre and DataMemRW to 0 while Reset=1.
REQ-033 The block SHALL treat Reset asserted in any state, including mid-MEM, as abandoning the instruction: no further write enable for it.

Structure
REQ-034 A shared package mcc_pkg SHALL hold the opcode constants, state encodings and ALUOp codes.
REQ-035 The MEM latency down-counter SHALL be one sub-module, mcc_wait_cnt, with load, decrement and zero flag.

Verification
REQ-036 Bench: Reset, then ADD -> states IF, ID, EXE_AL, WB_AL, IF; RegWre=1 with RegOut=1 only in WB_AL; ALUOp=000.
REQ-037 Bench: MEM_LAT=3, LW -> IF, ID, EXE_LS, MEM x3, WB_LD (7 cycles); ALUM2Reg=1 and RegWre=1 in WB_LD.
REQ-038 Bench: MEM_LAT=3, SW -> DataMemRW=1 for exactly 3 cycles; RegWre never 1.
REQ-039 Bench: BEQ with Zero=1 -> PCWre=1 and PCSrc=01 in EXE_BR; Zero=0 -> PCWre=0; BNE the inverse.
REQ-040 Bench: HALT -> PCWre=0 for 20 cycles; then Reset -> IF on the next edge.
REQ-041 Bench: Reset during the 2nd of 3 MEM cycles of SW -> IF on the next edge; no further DataMemRW.

Source files
------------

// File: rtl/mcc_pkg.sv
// mcc_pkg: shared definitions for the multi-cycle controller.
//   - opcode constants (6-bit instruction opcodes)
//   - FSM state encodings (3-bit visible states plus an internal HALT)
//   - ALUOp codes and the static per-opcode datapath decode
package mcc_pkg;

    // Instruction opcodes
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b011000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_BNE  = 6'b110001;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // ALU function codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Width of the MEM latency counter (MEM_LAT up to 15)
    localparam int CNT_W = 4;

    // The low three bits of the visible states are the debug State code.
    // HALT needs a fourth bit so it cannot alias any visible state.
    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_LS = 4'd2,
        S_MEM    = 4'd3,
        S_WB_LD  = 4'd4,
        S_EXE_BR = 4'd5,
        S_EXE_AL = 4'd6,
        S_WB_AL  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    // Per-opcode datapath controls that do not depend on the state
    typedef struct packed {
        logic [2:0] aluop;
        logic       alu_src_b;
        logic       alu_m2reg;
        logic       reg_out;
        logic       ext_sel;
    } dec_t;

    // Undefined opcodes, J and HALT fall into the default: ADD, no immediate,
    // sign-extend, nothing selected for write-back.
    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        d = '{aluop: ALU_ADD, alu_src_b: 1'b0, alu_m2reg: 1'b0,
              reg_out: 1'b0, ext_sel: 1'b1};
        case (op)
            OP_ADD:  begin d.reg_out = 1'b1; end
            OP_SUB:  begin d.aluop = ALU_SUB; d.reg_out = 1'b1; end
            OP_ADDI: begin d.alu_src_b = 1'b1; end
            OP_OR:   begin d.aluop = ALU_OR;  d.reg_out = 1'b1; end
            OP_AND:  begin d.aluop = ALU_AND; d.reg_out = 1'b1; end
            OP_ORI:  begin d.aluop = ALU_OR;  d.alu_src_b = 1'b1; d.ext_sel = 1'b0; end
            OP_SLT:  begin d.aluop = ALU_SLT; d.reg_out = 1'b1; end
            OP_SW:   begin d.alu_src_b = 1'b1; end
            OP_LW:   begin d.alu_src_b = 1'b1; d.alu_m2reg = 1'b1; end
            OP_BEQ,
            OP_BNE:  begin d.aluop = ALU_SUB; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mcc_wait_cnt.sv
// mcc_wait_cnt: MEM-phase latency down-counter.
//   CLK      in  clock
//   clr      in  synchronous clear (highest priority)
//   load     in  load load_val
//   load_val in  value loaded (cycles remaining after the first MEM cycle)
//   dec      in  decrement; saturates at zero
//   zero     out count is zero
module mcc_wait_cnt
    import mcc_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         CLK,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge CLK) begin
        if (clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: control FSM of a multi-cycle MIPS-like datapath.
//   CLK, Reset      clock; synchronous active-high reset
//   Opcode          opcode from the instruction register
//   Zero            ALU zero flag (used only for branch resolution)
//   PCWre, IRWre    PC / IR write enables
//   RegWre          register file write enable
//   DataMemRW       data memory write (1 = write)
//   ALUSrcB         ALU B operand = immediate
//   ALUM2Reg        write-back data from memory
//   RegOut          destination register = rd
//   ExtSel          sign-extend immediate (0 = zero-extend)
//   ALUOp           ALU function
//   PCSrc           00 PC+4, 01 branch target, 10 jump target
//   State           current state for debug (HALT reads 001)
module multi_cycle_ctrl
    import mcc_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int MEM_LAT = 1    // 1..15
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OP_W-1:0]    Opcode,
    input  logic               Zero,
    output logic               PCWre,
    output logic               IRWre,
    output logic               RegWre,
    output logic               DataMemRW,
    output logic               ALUSrcB,
    output logic               ALUM2Reg,
    output logic               RegOut,
    output logic               ExtSel,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSrc,
    output logic [2:0]         State
);

    state_t         state, state_nxt;
    logic [OP_W-1:0] op_q;
    logic [5:0]     live_op, held_op, cur_op;
    logic           mem_done;
    dec_t           dec;

    logic pc_wre, ir_wre, reg_wre, mem_wre;

    // The IR is written at the end of IF, so Opcode is first valid in ID.
    // ID decides on the live value; it is captured on the edge leaving ID
    // and every later state works from the captured copy.
    assign live_op = 6'(Opcode);
    assign held_op = 6'(op_q);
    assign cur_op  = (state == S_ID) ? live_op : held_op;
    assign dec     = decode(cur_op);

    always_ff @(posedge CLK) begin
        if (Reset)
            op_q <= '0;
        else if (state == S_ID)
            op_q <= Opcode;
    end

    // Loaded in EXE_LS with MEM_LAT-1 so MEM lasts exactly MEM_LAT cycles.
    mcc_wait_cnt #(.W(CNT_W)) u_wait (
        .CLK      (CLK),
        .clr      (Reset),
        .load     (state == S_EXE_LS),
        .load_val (CNT_W'(MEM_LAT - 1)),
        .dec      (state == S_MEM),
        .zero     (mem_done)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (Reset)
            state <= S_IF;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IF: state_nxt = S_ID;
            S_ID: begin
                case (live_op)
                    OP_ADD, OP_SUB, OP_ADDI, OP_OR,
                    OP_AND, OP_ORI, OP_SLT:     state_nxt = S_EXE_AL;
                    OP_LW, OP_SW:               state_nxt = S_EXE_LS;
                    OP_BEQ, OP_BNE:             state_nxt = S_EXE_BR;
                    OP_HALT:                    state_nxt = S_HALT;
                    default:                    state_nxt = S_IF;   // J and NOPs
                endcase
            end
            S_EXE_AL: state_nxt = S_WB_AL;
            S_WB_AL:  state_nxt = S_IF;
            S_EXE_BR: state_nxt = S_IF;
            S_EXE_LS: state_nxt = S_MEM;
            S_MEM: begin
                if (mem_done)
                    state_nxt = (held_op == OP_LW) ? S_WB_LD : S_IF;
            end
            S_WB_LD:  state_nxt = S_IF;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IF;
        endcase
    end

    // Output logic
    always_comb begin
        pc_wre  = 1'b0;
        ir_wre  = 1'b0;
        reg_wre = 1'b0;
        mem_wre = 1'b0;
        PCSrc   = 2'b00;
        State   = state[2:0];
        case (state)
            S_IF: begin
                pc_wre = 1'b1;
                ir_wre = 1'b1;
            end
            S_ID: begin
                // Jump resolves in ID, before the opcode is captured.
                if (live_op == OP_J) begin
                    pc_wre = 1'b1;
                    PCSrc  = 2'b10;
                end
            end
            S_EXE_BR: begin
                PCSrc = 2'b01;
                if (held_op == OP_BEQ)
                    pc_wre = Zero;
                else if (held_op == OP_BNE)
                    pc_wre = ~Zero;
            end
            S_MEM:   mem_wre = (held_op == OP_SW);
            S_WB_LD,
            S_WB_AL: reg_wre = 1'b1;
            S_HALT:  State = 3'b001;
            default: ;
        endcase
    end

    // Reset suppresses every write immediately, abandoning the instruction.
    assign PCWre     = pc_wre  & ~Reset;
    assign IRWre     = ir_wre  & ~Reset;
    assign RegWre    = reg_wre & ~Reset;
    assign DataMemRW = mem_wre & ~Reset;

    assign ALUSrcB  = dec.alu_src_b;
    assign ALUM2Reg = dec.alu_m2reg;
    assign RegOut   = dec.reg_out;
    assign ExtSel   = dec.ext_sel;
    assign ALUOp    = ALUOP_W'(dec.aluop);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] Opcode = 6'b0;
    logic       Zero = 1'b0;
    logic       PCWre, IRWre, RegWre, DataMemRW;
    logic       ALUSrcB, ALUM2Reg, RegOut, ExtSel;
    logic [2:0] ALUOp;
    logic [1:0] PCSrc;
    logic [2:0] State;

    int checks = 0;
    int errors = 0;

    multi_cycle_ctrl #(.OP_W(6), .ALUOP_W(3), .MEM_LAT(3)) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .DataMemRW(DataMemRW),
        .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg), .RegOut(RegOut), .ExtSel(ExtSel),
        .ALUOp(ALUOp), .PCSrc(PCSrc), .State(State)
    );

    always #5 CLK = ~CLK;

    // Opcodes
    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
    localparam logic [5:0] OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010;
    localparam logic [5:0] SLT = 6'b011000, SW = 6'b100110, LW = 6'b100111;
    localparam logic [5:0] BEQ = 6'b110000, BNE = 6'b110001, J = 6'b111000;
    localparam logic [5:0] HLT = 6'b111111, UND = 6'b101010;

    // Expected static decode {ALUOp[2:0], ALUSrcB, ALUM2Reg, RegOut, ExtSel}
    localparam logic [6:0] D_ADD  = 7'b000_0011, D_SUB = 7'b001_0011;
    localparam logic [6:0] D_ADDI = 7'b000_1001, D_OR  = 7'b011_0011;
    localparam logic [6:0] D_AND  = 7'b100_0011, D_ORI = 7'b011_1000;
    localparam logic [6:0] D_SLT  = 7'b101_0011, D_SW  = 7'b000_1001;
    localparam logic [6:0] D_LW   = 7'b000_1101, D_BR  = 7'b001_0001;
    localparam logic [6:0] D_NONE = 7'b000_0001;

    // Enables {PCWre, IRWre, RegWre, DataMemRW}
    localparam logic [3:0] E_NO = 4'b0000, E_IF = 4'b1100, E_WB = 4'b0010;
    localparam logic [3:0] E_MW = 4'b0001, E_PC = 4'b1000;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic [15:0] exp;   // {State, enables, PCSrc, decode}
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(string n, logic r, logic [5:0] op, logic z,
                                logic [2:0] st, logic [3:0] en, logic [1:0] pcs,
                                logic [6:0] d);
        vec_t v;
        v.name = n; v.rst = r; v.op = op; v.z = z;
        v.exp = {st, en, pcs, d};
        return v;
    endfunction

    function automatic logic [15:0] got_now();
        return {State, PCWre, IRWre, RegWre, DataMemRW, PCSrc,
                ALUOp, ALUSrcB, ALUM2Reg, RegOut, ExtSel};
    endfunction

    // Drive one cycle's inputs, compare outputs mid-cycle, advance one clock.
    task automatic apply(input vec_t v);
        logic [15:0] g;
        Reset = v.rst; Opcode = v.op; Zero = v.z;
        #1;
        g = got_now();
        checks++;
        if (g !== v.exp) begin
            errors++;
            $display("FAIL %s: got st=%b en=%b pcs=%b dec=%b, exp st=%b en=%b pcs=%b dec=%b",
                     v.name, g[15:13], g[12:9], g[8:7], g[6:0],
                     v.exp[15:13], v.exp[12:9], v.exp[8:7], v.exp[6:0]);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // ---- table: reset then a program covering every instruction class
        tv.push_back(mk("rst_hold", 1, ADD, 0, 3'd0, E_NO, 2'b00, D_ADD));
        // ADD
        tv.push_back(mk("add_if",  0, ADD, 0, 3'd0, E_IF, 2'b00, D_ADD));
        tv.push_back(mk("add_id",  0, ADD, 0, 3'd1, E_NO, 2'b00, D_ADD));
        tv.push_back(mk("add_exe", 0, ADD, 1, 3'd6, E_NO, 2'b00, D_ADD));
        tv.push_back(mk("add_wb",  0, ADD, 0, 3'd7, E_WB, 2'b00, D_ADD));
        // LW, MEM_LAT=3
        tv.push_back(mk("lw_if",   0, LW, 0, 3'd0, E_IF, 2'b00, D_ADD));
        tv.push_back(mk("lw_id",   0, LW, 0, 3'd1, E_NO, 2'b00, D_LW));
        tv.push_back(mk("lw_exe",  0, LW, 0, 3'd2, E_NO, 2'b00, D_LW));
        tv.push_back(mk("lw_mem1", 0, LW, 0, 3'd3, E_NO, 2'b00, D_LW));
        tv.push_back(mk("lw_mem2", 0, LW, 0, 3'd3, E_NO, 2'b00, D_LW));
        tv.push_back(mk("lw_mem3", 0, LW, 0, 3'd3, E_NO, 2'b00, D_LW));
        tv.push_back(mk("lw_wb",   0, LW, 0, 3'd4, E_WB, 2'b00, D_LW));
        // SW: three write cycles, no register write
        tv.push_back(mk("sw_if",   0, SW, 0, 3'd0, E_IF, 2'b00, D_LW));
        tv.push_back(mk("sw_id",   0, SW, 0, 3'd1, E_NO, 2'b00, D_SW));
        tv.push_back(mk("sw_exe",  0, SW, 0, 3'd2, E_NO, 2'b00, D_SW));
        tv.push_back(mk("sw_mem1", 0, SW, 0, 3'd3, E_MW, 2'b00, D_SW));
        tv.push_back(mk("sw_mem2", 0, SW, 0, 3'd3, E_MW, 2'b00, D_SW));
        tv.push_back(mk("sw_mem3", 0, SW, 0, 3'd3, E_MW, 2'b00, D_SW));
        // BEQ taken / not taken
        tv.push_back(mk("beq1_if", 0, BEQ, 1, 3'd0, E_IF, 2'b00, D_SW));
        tv.push_back(mk("beq1_id", 0, BEQ, 1, 3'd1, E_NO, 2'b00, D_BR));
        tv.push_back(mk("beq1_ex", 0, BEQ, 1, 3'd5, E_PC, 2'b01, D_BR));
        tv.push_back(mk("beq0_if", 0, BEQ, 0, 3'd0, E_IF, 2'b00, D_BR));
        tv.push_back(mk("beq0_id", 0, BEQ, 0, 3'd1, E_NO, 2'b00, D_BR));
        tv.push_back(mk("beq0_ex", 0, BEQ, 0, 3'd5, E_NO, 2'b01, D_BR));
        // BNE inverse
        tv.push_back(mk("bne0_if", 0, BNE, 0, 3'd0, E_IF, 2'b00, D_BR));
        tv.push_back(mk("bne0_id", 0, BNE, 0, 3'd1, E_NO, 2'b00, D_BR));
        tv.push_back(mk("bne0_ex", 0, BNE, 0, 3'd5, E_PC, 2'b01, D_BR));
        tv.push_back(mk("bne1_if", 0, BNE, 1, 3'd0, E_IF, 2'b00, D_BR));
        tv.push_back(mk("bne1_id", 0, BNE, 1, 3'd1, E_NO, 2'b00, D_BR));
        tv.push_back(mk("bne1_ex", 0, BNE, 1, 3'd5, E_NO, 2'b01, D_BR));
        // ORI: zero-extend
        tv.push_back(mk("ori_if",  0, ORI, 0, 3'd0, E_IF, 2'b00, D_BR));
        tv.push_back(mk("ori_id",  0, ORI, 0, 3'd1, E_NO, 2'b00, D_ORI));
        tv.push_back(mk("ori_exe", 0, ORI, 0, 3'd6, E_NO, 2'b00, D_ORI));
        tv.push_back(mk("ori_wb",  0, ORI, 0, 3'd7, E_WB, 2'b00, D_ORI));
        // J resolves in ID
        tv.push_back(mk("j_if",    0, J, 0, 3'd0, E_IF, 2'b00, D_ORI));
        tv.push_back(mk("j_id",    0, J, 0, 3'd1, E_PC, 2'b10, D_NONE));
        // Undefined opcode acts as NOP
        tv.push_back(mk("und_if",  0, UND, 0, 3'd0, E_IF, 2'b00, D_NONE));
        tv.push_back(mk("und_id",  0, UND, 0, 3'd1, E_NO, 2'b00, D_NONE));
        // SLT, AND, ADDI, OR
        tv.push_back(mk("slt_if",  0, SLT, 0, 3'd0, E_IF, 2'b00, D_NONE));
        tv.push_back(mk("slt_id",  0, SLT, 0, 3'd1, E_NO, 2'b00, D_SLT));
        tv.push_back(mk("slt_exe", 0, SLT, 0, 3'd6, E_NO, 2'b00, D_SLT));
        tv.push_back(mk("slt_wb",  0, SLT, 0, 3'd7, E_WB, 2'b00, D_SLT));
        tv.push_back(mk("and_if",  0, AND_, 0, 3'd0, E_IF, 2'b00, D_SLT));
        tv.push_back(mk("and_id",  0, AND_, 0, 3'd1, E_NO, 2'b00, D_AND));
        tv.push_back(mk("and_exe", 0, AND_, 0, 3'd6, E_NO, 2'b00, D_AND));
        tv.push_back(mk("and_wb",  0, AND_, 0, 3'd7, E_WB, 2'b00, D_AND));
        tv.push_back(mk("addi_if", 0, ADDI, 0, 3'd0, E_IF, 2'b00, D_AND));
        tv.push_back(mk("addi_id", 0, ADDI, 0, 3'd1, E_NO, 2'b00, D_ADDI));
        tv.push_back(mk("addi_ex", 0, ADDI, 0, 3'd6, E_NO, 2'b00, D_ADDI));
        tv.push_back(mk("addi_wb", 0, ADDI, 0, 3'd7, E_WB, 2'b00, D_ADDI));
        tv.push_back(mk("or_if",   0, OR_, 0, 3'd0, E_IF, 2'b00, D_ADDI));
        tv.push_back(mk("or_id",   0, OR_, 0, 3'd1, E_NO, 2'b00, D_OR));
        tv.push_back(mk("or_exe",  0, OR_, 0, 3'd6, E_NO, 2'b00, D_OR));
        tv.push_back(mk("or_wb",   0, OR_, 0, 3'd7, E_WB, 2'b00, D_OR));

        // Reset asserted from time 0; take one edge before the table.
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        foreach (tv[i]) apply(tv[i]);

        // ---- opcode changes after ID must not affect SUB
        apply(mk("sub_if",   0, SUB, 0, 3'd0, E_IF, 2'b00, D_OR));
        apply(mk("sub_id",   0, SUB, 0, 3'd1, E_NO, 2'b00, D_SUB));
        apply(mk("sub_exe",  0, LW,  1, 3'd6, E_NO, 2'b00, D_SUB));
        apply(mk("sub_wb",   0, BEQ, 1, 3'd7, E_WB, 2'b00, D_SUB));

        // ---- reset during the 2nd MEM cycle of SW abandons the store
        apply(mk("swr_if",   0, SW, 0, 3'd0, E_IF, 2'b00, D_SUB));
        apply(mk("swr_id",   0, SW, 0, 3'd1, E_NO, 2'b00, D_SW));
        apply(mk("swr_exe",  0, SW, 0, 3'd2, E_NO, 2'b00, D_SW));
        apply(mk("swr_mem1", 0, SW, 0, 3'd3, E_MW, 2'b00, D_SW));
        apply(mk("swr_mem2", 1, SW, 0, 3'd3, E_NO, 2'b00, D_SW));
        apply(mk("swr_if2",  0, UND, 0, 3'd0, E_IF, 2'b00, D_ADD));
        apply(mk("swr_id2",  0, UND, 0, 3'd1, E_NO, 2'b00, D_NONE));
        apply(mk("swr_if3",  0, UND, 0, 3'd0, E_IF, 2'b00, D_NONE));
        apply(mk("swr_id3",  0, UND, 0, 3'd1, E_NO, 2'b00, D_NONE));

        // ---- HALT holds with no enables until reset
        apply(mk("hlt_if",   0, HLT, 0, 3'd0, E_IF, 2'b00, D_NONE));
        apply(mk("hlt_id",   0, HLT, 0, 3'd1, E_NO, 2'b00, D_NONE));
        for (int k = 0; k < 20; k++)
            apply(mk($sformatf("hlt_hold%0d", k), 0, (k % 2 == 0) ? J : ADD, k[0],
                     3'd1, E_NO, 2'b00, D_NONE));
        apply(mk("hlt_rst",  1, J,   0, 3'd1, E_NO, 2'b00, D_NONE));
        apply(mk("hlt_out",  0, ADD, 0, 3'd0, E_IF, 2'b00, D_ADD));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
